dmem_responder: RTL and testbench

- Responder (memory side) of the load/store data-memory interface that the RV32I core's datapath drives.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a configurable access latency and performs RV32I byte/half/word lane handling with sign/zero extension.
- Returns data or a store acknowledge over a valid/ready response channel. Lets the core (and later the pipelined core) be exercised against a non-zero-latency memory.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the RV32I load/store interface: one request at a time,
// fixed access latency, byte/half/word lane handling with sign/zero extension.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [33:0] AddrLimit = 34'(DEPTH) << 2;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e      r_state, w_state_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_cnt;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic [31:0]   w_rword, w_wword, w_load_data, w_rsp_data;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [3:0]    w_be;
   logic          w_err, w_oor, w_access;

   assign w_idx    = r_addr[AW+1:2];
   assign w_rword  = r_mem[w_idx];
   assign w_byte   = w_rword[{r_addr[1:0], 3'b000} +: 8];
   assign w_half   = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
   assign w_oor    = {2'b00, r_addr} >= AddrLimit;
   assign w_access = (r_state == StBusy) && (r_cnt == 4'd0);

   assign req_ready = (r_state == StIdle);
   assign rsp_valid = (r_state == StResp);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= StIdle;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (req_valid) w_state_next = StBusy;
         StBusy: if (r_cnt == 4'd0) w_state_next = StResp;
         StResp: if (rsp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Lane decode and legality of the latched request.
   always_comb begin
      w_err       = 1'b0;
      w_load_data = 32'h0;
      w_be        = 4'b0000;
      w_wword     = r_wdata;
      case (r_funct3)
         3'b000: begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
            w_be        = 4'b0001 << r_addr[1:0];
            w_wword     = {4{r_wdata[7:0]}};
         end
         3'b001: begin
            w_err       = r_addr[0];
            w_load_data = {{16{w_half[15]}}, w_half};
            w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wword     = {2{r_wdata[15:0]}};
         end
         3'b010: begin
            w_err       = (r_addr[1:0] != 2'b00);
            w_load_data = w_rword;
            w_be        = 4'b1111;
         end
         3'b100: begin
            w_err       = r_we;
            w_load_data = {24'h0, w_byte};
         end
         3'b101: begin
            w_err       = r_we | r_addr[0];
            w_load_data = {16'h0, w_half};
         end
         default: w_err = 1'b1;
      endcase
      if (w_oor) w_err = 1'b1;
      w_rsp_data = (r_we || w_err) ? 32'h0 : w_load_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_cnt    <= 4'd0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == StIdle && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 4'(LATENCY - 1);
         end
         if (r_state == StBusy && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
         if (w_access) begin
            r_rdata <= w_rsp_data;
            r_err   <= w_err;
         end
      end
   end

   // Array is never reset; a reset edge suppresses any commit.
   always_ff @(posedge clk) begin
      if (rst && w_access && r_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for most checks and a
// LATENCY=4 instance for the reset-during-BUSY case, selected by r_sel.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, rsp_ready, r_sel;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;

   logic        w_rdy2, w_val2, w_err2, w_rdy4, w_val4, w_err4;
   logic [31:0] w_data2, w_data4;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~r_sel), .req_ready(w_rdy2),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(w_val2), .rsp_ready(rsp_ready), .rsp_rdata(w_data2), .rsp_err(w_err2)
   );

   dmem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid & r_sel), .req_ready(w_rdy4),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(w_val4), .rsp_ready(rsp_ready), .rsp_rdata(w_data4), .rsp_err(w_err4)
   );

   assign req_ready = r_sel ? w_rdy4  : w_rdy2;
   assign rsp_valid = r_sel ? w_val4  : w_val2;
   assign rsp_rdata = r_sel ? w_data4 : w_data2;
   assign rsp_err   = r_sel ? w_err4  : w_err2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issue one request, check latency, response and handshake. Called #1 after a posedge.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                         input logic [31:0] exp_data, input logic exp_err, input bit hold_rdy);
      int n;
      check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
      rsp_ready  = hold_rdy;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".latency"}, n, lat);
      check({tag, ".rdata"}, rsp_rdata, exp_data);
      check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, ".drop_valid"}, {31'h0, rsp_valid}, 32'h0);
   endtask

   logic [31:0] hold_data;

   initial begin
      r_sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("rst.req_ready", {31'h0, req_ready}, 32'h1);
      check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst.rdata", rsp_rdata, 32'h0);
      check("rst.err", {31'h0, rsp_err}, 32'h0);

      do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b0);
      do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
      do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 1'b0);
      do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h000000DE, 1'b0, 1'b0);
      do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 1'b0);
      do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 32'h0000BEEF, 1'b0, 1'b1);
      do_req("sb11", 1'b1, 3'b000, 32'h11, 32'h55, 2, 32'h0, 1'b0, 1'b0);
      do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD55EF, 1'b0, 1'b0);
      do_req("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 2, 32'h00000055, 1'b0, 1'b0);

      do_req("lw12err", 1'b0, 3'b010, 32'h12, 32'h0, 2, 32'h0, 1'b1, 1'b0);
      do_req("sh11err", 1'b1, 3'b001, 32'h11, 32'h1234, 2, 32'h0, 1'b1, 1'b0);
      do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD55EF, 1'b0, 1'b0);
      do_req("lwoor", 1'b0, 3'b010, 32'h400, 32'h0, 2, 32'h0, 1'b1, 1'b0);
      do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 2, 32'h0, 1'b1, 1'b0);
      do_req("sbu", 1'b1, 3'b100, 32'h10, 32'hFF, 2, 32'h0, 1'b1, 1'b0);
      do_req("sh12", 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 2, 32'h0, 1'b0, 1'b0);
      do_req("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h123455EF, 1'b0, 1'b0);

      // Backpressure: response held five cycles while a stray store is pulsed.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 40 && !rsp_valid; i++) begin
         @(posedge clk); #1;
      end
      check("bp.valid0", {31'h0, rsp_valid}, 32'h1);
      hold_data = 32'h123455EF;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         check("bp.valid", {31'h0, rsp_valid}, 32'h1);
         check("bp.rdata", rsp_rdata, hold_data);
         check("bp.err", {31'h0, rsp_err}, 32'h0);
         check("bp.req_ready", {31'h0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp.release_valid", {31'h0, rsp_valid}, 32'h0);
      check("bp.release_ready", {31'h0, req_ready}, 32'h1);
      do_req("lw10e", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h123455EF, 1'b0, 1'b0);

      // Reset during BUSY on the LATENCY=4 instance discards the store.
      r_sel = 1'b1;
      #1;
      do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h12345678, 4, 32'h0, 1'b0, 1'b0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("rmid.req_ready", {31'h0, req_ready}, 32'h1);
      check("rmid.rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rmid.rdata", rsp_rdata, 32'h0);
      check("rmid.err", {31'h0, rsp_err}, 32'h0);
      do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 4, 32'h12345678, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
